seq_accumulator_16: RTL and testbench
=====================================

Name: seq_accumulator_16

Overview:
Sequential accumulator that sits directly downstream of the 16-bit ripple adder stage. It sums a fixed-length burst of 16-bit operands using the same modulo-2^16 arithmetic as the adder, with the carry-out no longer dropped. It tracks a sticky overflow flag and presents the burst total on a valid/ready output port. Used wherever the datapath needs multi-operand sums, such as checksums or running totals.

Parameters:
WIDTH, 16, operand/accumulator width in bits
NUM_TERMS, 4, operands per burst; legal range 1..255
CNT_W, $clog2(NUM_TERMS+1), term counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of current burst
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand
in_data  input  WIDTH  operand
out_valid  output  1  burst result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  burst total, modulo 2^WIDTH (or saturated, see Optional Feature)
out_ovf  output  1  at least one carry-out occurred during the burst
term_cnt  output  CNT_W  operands accepted in the current burst

Behaviour:
- Reset: clock and reset are fixed. One clock, clk. Reset is asynchronous and active-low, on reset_n.
- Reset values: state=ACCUM, acc=0, term_cnt=0, out_valid=0, out_sum=0, out_ovf=0, in_ready=1. Release of reset is synchronous to clk.
- States: ACCUM and DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat occurs on in_valid&&in_ready.
  - On a beat, compute the WIDTH+1-bit sum {c,s} = acc + in_data. Then acc<=s, ovf<=ovf|c, term_cnt<=term_cnt+1.
  - If the beat is term NUM_TERMS (term_cnt==NUM_TERMS-1 before the beat), move to DONE. In the same edge: out_sum<=s, out_ovf<=ovf|c, out_valid<=1.
- DONE:
  - in_ready=0, and in_data is ignored.
  - out_valid, out_sum and out_ovf stay stable until out_valid&&out_ready.
  - On that handshake: acc=0, ovf=0, term_cnt=0, out_valid=0, then return to ACCUM.
  - New operands are accepted from the cycle after the handshake. There is no same-cycle restart.
- Latency: out_valid rises on the clock edge that accepts the final operand, so it is visible 1 cycle after that operand is presented.
- Throughput: NUM_TERMS+1 cycles per burst minimum, at 1 operand/cycle plus 1 handshake cycle.
- NUM_TERMS=1: every accepted beat goes straight to DONE.
- clear:
  - Highest priority, in either state.
  - Next edge: acc=0, ovf=0, term_cnt=0, out_valid=0, state=ACCUM.
  - Any beat or output handshake in the same cycle is discarded.
  - out_sum and out_ovf keep their last values but are meaningless while out_valid=0.
- Wrap-around: acc arithmetic is modulo 2^WIDTH. Each carry sets the sticky ovf flag; ovf never clears mid-burst.
- Async reset mid-burst: everything returns to the reset values immediately. The partial burst is lost.
- out_valid must not depend combinationally on out_ready.
- in_ready is a function of state only.

Optional Feature:
Macro: SEQ_ACC_SATURATE_EN
- Defined:
  - On any beat with carry-out, acc is set to all-ones (16'hFFFF).
  - Once saturated, acc stays all-ones for the rest of the burst.
  - out_sum reports 16'hFFFF whenever out_ovf=1.
- Undefined: out_sum wraps modulo 2^WIDTH, and out_ovf alone reports the overflow.

Test Plan:
1. Reset then 4 beats 0x0001, 0x0002, 0x0003, 0x0004 with out_ready=1:
   - out_valid=1 for 1 cycle with out_sum=0x000A, out_ovf=0.
   - in_ready=0 during that cycle.
2. Beats 0x8000, 0x8000, 0x0001, 0x0002, saturate macro undefined:
   - out_sum=0x0003, out_ovf=1.
   - With SEQ_ACC_SATURATE_EN defined: out_sum=0xFFFF, out_ovf=1.
3. Hold out_ready=0 for 5 cycles after burst of 0x1111 x4:
   - out_sum=0x4444 stays stable and out_valid stays 1.
   - in_ready=0 and extra in_valid beats are ignored.
   - Next burst after release sums from 0.
4. Gaps in in_valid (beats on cycles 0, 3, 4, 9):
   - term_cnt steps 1, 2, 3.
   - Result is valid after the cycle-9 edge.
5. clear asserted after 2 beats (0x00FF, 0x0F00):
   - term_cnt=0 and state ACCUM next cycle.
   - Following 4 beats of 0x0001 give out_sum=0x0004, out_ovf=0.
6. reset_n pulsed low asynchronously (mid-clock) after 3 beats:
   - All outputs return to reset values immediately.
   - in_ready=1 after release.
   - The next full burst sums correctly.

Source files
------------

// File: rtl/seq_accumulator_16.sv
// rtl/seq_accumulator_16.sv - burst accumulator with sticky overflow and valid/ready result port
// Optional saturation on carry-out when SEQ_ACC_SATURATE_EN is defined.
module seq_accumulator_16 #(
  parameter int WIDTH     = 16,
  parameter int NUM_TERMS = 4,
  localparam int CNT_W    = $clog2(NUM_TERMS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;
  logic             beat;
  logic             last_beat;
  logic             handshake;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    beat       = in_valid && (state == ACCUM);
    last_beat  = beat && (term_cnt == LAST_TERM);
    handshake  = out_ready && (state == DONE);
    sum_full   = {1'b0, acc} + {1'b0, in_data};
    ovf_next   = ovf | sum_full[WIDTH];
`ifdef SEQ_ACC_SATURATE_EN
    // Any carry so far pins the accumulator to all-ones for the rest of the burst.
    acc_next   = ovf_next ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    acc_next   = sum_full[WIDTH-1:0];
`endif
    case (state)
      ACCUM:   if (last_beat) state_next = DONE;
      DONE:    if (handshake) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
    if (clear) state_next = ACCUM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // out_sum/out_ovf are left untouched by clear; they only matter while out_valid=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      ovf      <= 1'b0;
      term_cnt <= '0;
      out_sum  <= '0;
      out_ovf  <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      ovf      <= 1'b0;
      term_cnt <= '0;
    end else if (beat) begin
      acc      <= acc_next;
      ovf      <= ovf_next;
      term_cnt <= term_cnt + CNT_W'(1);
      if (last_beat) begin
        out_sum <= acc_next;
        out_ovf <= ovf_next;
      end
    end else if (handshake) begin
      acc      <= '0;
      ovf      <= 1'b0;
      term_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_seq_accumulator_16.sv
// tb/tb_seq_accumulator_16.sv - directed self-checking bench for seq_accumulator_16
module tb_seq_accumulator_16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic [2:0]  term_cnt;

  int passed = 0;
  int total  = 0;

  seq_accumulator_16 dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .term_cnt(term_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (out_sum !== 16'h0000) $display("FAIL rst_out_sum: got %h expected 0000", out_sum); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL rst_out_ovf: got %b expected 0", out_ovf); else passed++;
    total++; if (term_cnt !== 3'd0) $display("FAIL rst_term_cnt: got %0d expected 0", term_cnt); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_beat(16'h0001); do_beat(16'h0002); do_beat(16'h0003);
    total++; if (term_cnt !== 3'd3) $display("FAIL basic_cnt: got %0d expected 3", term_cnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else passed++;
    do_beat(16'h0004);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_sum !== 16'h000A) $display("FAIL basic_sum: got %h expected 000a", out_sum); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", out_ovf); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready: got %b expected 0", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b expected 1", in_ready); else passed++;
    total++; if (term_cnt !== 3'd0) $display("FAIL basic_cnt_clr: got %0d expected 0", term_cnt); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_sum;
`ifdef SEQ_ACC_SATURATE_EN
    exp_sum = 16'hFFFF;
`else
    exp_sum = 16'h0003;
`endif
    out_ready = 1'b1;
    do_beat(16'h8000); do_beat(16'h8000); do_beat(16'h0001); do_beat(16'h0002);
    total++; if (out_valid !== 1'b1) $display("FAIL wrap_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_sum !== exp_sum) $display("FAIL wrap_sum: got %h expected %h", out_sum, exp_sum); else passed++;
    total++; if (out_ovf !== 1'b1) $display("FAIL wrap_ovf: got %b expected 1", out_ovf); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_beat(16'h1111);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_sum !== 16'h4444) $display("FAIL hold_sum[%0d]: got %h expected 4444", i, out_sum); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); else passed++;
      total++; if (term_cnt !== 3'd4) $display("FAIL hold_cnt[%0d]: got %0d expected 4", i, term_cnt); else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL hold_release: got %b expected 0", out_valid); else passed++;
    for (int i = 0; i < 4; i++) do_beat(16'h0010);
    total++; if (out_sum !== 16'h0040) $display("FAIL hold_next_sum: got %h expected 0040", out_sum); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL hold_next_ovf: got %b expected 0", out_ovf); else passed++;
    step();
  endtask

  task automatic test_gaps();
    int k;
    logic hit;
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      hit = (c == 0) || (c == 3) || (c == 4) || (c == 9);
      in_valid = hit;
      in_data  = 16'h0005;
      step();
      if (hit) k++;
      if (hit && c < 9) begin
        total++; if (term_cnt !== 3'(k)) $display("FAIL gap_cnt[c%0d]: got %0d expected %0d", c, term_cnt, k); else passed++;
      end
      if (c == 8) begin
        total++; if (out_valid !== 1'b0) $display("FAIL gap_early: got %b expected 0", out_valid); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL gap_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_sum !== 16'h0014) $display("FAIL gap_sum: got %h expected 0014", out_sum); else passed++;
    step();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    do_beat(16'h00FF); do_beat(16'h0F00);
    total++; if (term_cnt !== 3'd2) $display("FAIL clr_pre_cnt: got %0d expected 2", term_cnt); else passed++;
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    step();
    clear = 1'b0; in_valid = 1'b0;
    total++; if (term_cnt !== 3'd0) $display("FAIL clr_cnt: got %0d expected 0", term_cnt); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL clr_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL clr_out_valid: got %b expected 0", out_valid); else passed++;
    for (int i = 0; i < 4; i++) do_beat(16'h0001);
    total++; if (out_valid !== 1'b1) $display("FAIL clr_next_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_sum !== 16'h0004) $display("FAIL clr_next_sum: got %h expected 0004", out_sum); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL clr_next_ovf: got %b expected 0", out_ovf); else passed++;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    do_beat(16'h0100); do_beat(16'h0100); do_beat(16'h0100);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (term_cnt !== 3'd0) $display("FAIL arst_cnt: got %0d expected 0", term_cnt); else passed++;
    total++; if (out_sum !== 16'h0000) $display("FAIL arst_sum: got %h expected 0000", out_sum); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b expected 1", in_ready); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL arst_release_ready: got %b expected 1", in_ready); else passed++;
    do_beat(16'h0002); do_beat(16'h0003); do_beat(16'h0004); do_beat(16'h0005);
    total++; if (out_valid !== 1'b1) $display("FAIL arst_next_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_sum !== 16'h000E) $display("FAIL arst_next_sum: got %h expected 000e", out_sum); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_gaps();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
